// File: rtl/fas_pkg.sv
//------------------------------------------------------------------------------
// fas_pkg : shared FFT frame types, bin slicing and analyzer state encoding
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fas_pkg;

  localparam int FFT_NBIN = 16;
  localparam int FFT_DW   = 16;
  localparam int FREQ_W   = 4;
  localparam int BUS_W    = FFT_NBIN * 2 * FFT_DW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  typedef logic [FREQ_W-1:0]   bin_idx_t;
  typedef logic [2*FFT_DW-1:0] mag_t;

  // Bin k occupies bus[32k+31:32k] as {re, im}.
  function automatic cplx_t bin_slice(input logic [BUS_W-1:0] bus, input bin_idx_t k);
    return cplx_t'(bus[{k, 5'b0} +: 2*FFT_DW]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fas_cmag2.sv
//------------------------------------------------------------------------------
// fas_cmag2 : combinational squared magnitude re^2 + im^2 of one FFT bin
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fas_cmag2
  import fas_pkg::*;
(
  input  logic [2*FFT_DW-1:0] bin,
  output logic [2*FFT_DW-1:0] mag
);

  cplx_t c;
  logic signed [2*FFT_DW-1:0] re_x;
  logic signed [2*FFT_DW-1:0] im_x;
  logic signed [2*FFT_DW-1:0] re_sq;
  logic signed [2*FFT_DW-1:0] im_sq;

  assign c     = cplx_t'(bin);
  assign re_x  = {{FFT_DW{c.re[FFT_DW-1]}}, c.re};
  assign im_x  = {{FFT_DW{c.im[FFT_DW-1]}}, c.im};
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  // Each square is at most 2^30, so the unsigned sum never exceeds 2^31.
  assign mag = mag_t'(re_sq) + mag_t'(im_sq);

endmodule

`default_nettype wire

// File: rtl/fas_peak_analyzer.sv
//------------------------------------------------------------------------------
// fas_peak_analyzer : finds the largest-|X|^2 bin of each FFT frame; optional
// peak threshold and peak_mag port under FAS_ANA_THRESH_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fas_peak_analyzer
  import fas_pkg::*;
#(
  parameter int          DW         = 16,
  parameter int          NBIN       = 16,
  parameter logic [31:0] MAG_THRESH = 32'h0001_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fft_valid,
  input  logic [NBIN*2*DW-1:0]    fft_bus,
  output logic                    done,
  output logic [$clog2(NBIN)-1:0] freq,
  output logic                    busy,
  output logic                    overflow
`ifdef FAS_ANA_THRESH_EN
  ,
  output logic [2*DW-1:0]         peak_mag
`endif
);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [BUS_W-1:0] work;
  logic [BUS_W-1:0] pend;
  logic             pend_vld;
  logic             pend_vld_nxt;
  bin_idx_t         idx;
  bin_idx_t         best_idx;
  bin_idx_t         win_idx;
  mag_t             best_mag;
  mag_t             win_mag;
  mag_t             cur_mag;
  logic [31:0]      cur_bin;
  logic             scan_end;
  logic             load_new;
  logic             load_pend;
  logic             to_pend;
  logic             drop;
  logic             report;

  assign cur_bin = bin_slice(work, idx);

  fas_cmag2 u_cmag2 (
    .bin (cur_bin),
    .mag (cur_mag)
  );

  // Strict compare keeps the earlier index on ties.
  assign win_idx = (cur_mag > best_mag) ? idx : best_idx;
  assign win_mag = (cur_mag > best_mag) ? cur_mag : best_mag;

`ifdef FAS_ANA_THRESH_EN
  assign report = (win_mag >= MAG_THRESH);
`else
  logic unused_thresh;
  assign unused_thresh = ^MAG_THRESH;
  assign report        = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fft_valid) state_nxt = ST_SCAN;
      ST_SCAN: if (scan_end && !pend_vld && !fft_valid) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_end  = 1'b0;
    load_new  = 1'b0;
    load_pend = 1'b0;
    to_pend   = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE: load_new = fft_valid;
      ST_SCAN: begin
        if (idx == bin_idx_t'(FFT_NBIN-1)) begin
          scan_end = 1'b1;
          // A frame arriving while pending drains refills pending without loss.
          if (pend_vld) begin
            load_pend = 1'b1;
            to_pend   = fft_valid;
          end else begin
            load_new  = fft_valid;
          end
        end else if (fft_valid) begin
          drop    = pend_vld;
          to_pend = !pend_vld;
        end
      end
      default: ;
    endcase
    pend_vld_nxt = (pend_vld && !load_pend) || to_pend;
  end

  always_ff @(posedge clk) begin
    if (to_pend)       pend <= fft_bus;
    if (load_pend)     work <= pend;
    else if (load_new) work <= fft_bus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      best_idx <= '0;
      best_mag <= '0;
      pend_vld <= 1'b0;
      done     <= 1'b0;
      freq     <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef FAS_ANA_THRESH_EN
      peak_mag <= '0;
`endif
    end else begin
      done     <= scan_end && report;
      busy     <= (state_nxt == ST_SCAN) || pend_vld_nxt;
      pend_vld <= pend_vld_nxt;
      if (drop) overflow <= 1'b1;
      if (load_new || load_pend || scan_end) begin
        idx      <= '0;
        best_idx <= '0;
        best_mag <= '0;
      end else if (state == ST_SCAN) begin
        idx      <= idx + 1'b1;
        best_idx <= win_idx;
        best_mag <= win_mag;
      end
      if (scan_end && report) begin
        freq     <= win_idx;
`ifdef FAS_ANA_THRESH_EN
        peak_mag <= win_mag;
`endif
      end
    end
  end

endmodule

`default_nettype wire
